chained_step_counter: RTL

Parametrised successor to the two-stage nested-adder counter. A WIDTH-bit counter whose next value comes from a registered chain of STAGES adder stages, each adding its own step. The block adds a start/ready handshake, a done pulse, a load port, wrap or saturate arithmetic and a sticky overflow flag. It sits as a leaf datapath block under a sequencing controller and is the standard regression for nested submodule binding at generalised width and depth.

---
 rtl/chained_step_counter_pkg.sv | 33 +++
 rtl/chained_step_counter_step_adder_stage.sv | 27 ++
 rtl/chained_step_counter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/chained_step_counter_pkg.sv
// Shared types and constants for the chained step counter.
package chained_step_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_STAGES = 8;
  // Stage index runs 0..MAX_STAGES, so it needs room for MAX_STAGES itself.
  localparam int IDX_W = $clog2(MAX_STAGES + 1);

  // Width-generic add on a fixed 33-bit sum. Operands must already fit in
  // 'width' bits. Returns {carry, result}; on carry the result is either the
  // wrapped low bits or all-ones when saturating.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width,
                                          input bit saturate);
    logic [32:0] sum;
    logic [32:0] mask;
    logic        carry;
    sum   = {1'b0, a} + {1'b0, b};
    mask  = (33'd1 << width) - 33'd1;
    // Any bit above the operand width can only be the carry out.
    carry = |(sum & ~mask);
    if (carry) begin
      sum = saturate ? mask : (sum & mask);
    end
    return {carry, sum[31:0]};
  endfunction

endpackage

// File: rtl/chained_step_counter_step_adder_stage.sv
// One adder stage: WIDTH+1-bit sum with wrap or clamp on carry.
module step_adder_stage
  import chained_step_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] raw_w;

  // Full-width sum; a carry either wraps (low bits kept) or clamps to all-ones.
  always_comb begin
    raw_w   = {1'b0, a_i} + {1'b0, b_i};
    carry_o = raw_w[WIDTH];
    if (raw_w[WIDTH] && (SATURATE != 0)) begin
      sum_o = '1;
    end else begin
      sum_o = raw_w[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/chained_step_counter.sv
// Counter advanced by a registered chain of STAGES adder stages per pass.
//
// Handshake: ready_o is high exactly while the block is IDLE. On a rising
// edge with ready_o=1, load_i=1 loads load_value_i (and clears overflow);
// otherwise start_i=1 accepts a pass and samples step_i on that edge only.
// While busy (ready_o=0) start_i and load_i are ignored, never queued.
// done_o pulses for one cycle when count_o takes the chain result.
module chained_step_counter
  import chained_step_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 2,
  parameter int SATURATE = 0
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic                    ready_o,
  input  logic [STAGES*WIDTH-1:0] step_i,
  input  logic                    load_i,
  input  logic [WIDTH-1:0]        load_value_i,
  output logic [WIDTH-1:0]        count_o,
  output logic                    done_o,
  output logic                    overflow_o,
  output state_t                  state_o
);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]        count_q, count_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic [STAGES*WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0]        stage_q [STAGES];
  logic [WIDTH-1:0]        stage_d [STAGES];

  logic [WIDTH-1:0]        step_view_w [STAGES];
  logic [WIDTH-1:0]        sum_w [STAGES];
  logic [STAGES-1:0]       carry_w;

  // Stage 0 adds the live step on the accept edge; later stages use the latch.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_w;
    if (k == 0) begin : g_first
      assign a_w = count_q;
    end else begin : g_next
      assign a_w = stage_q[k-1];
    end
    assign step_view_w[k] = (state_q == IDLE) ? step_i[k*WIDTH +: WIDTH]
                                              : step_q[k*WIDTH +: WIDTH];
    step_adder_stage #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_stage (
      .a_i     (a_w),
      .b_i     (step_view_w[k]),
      .sum_o   (sum_w[k]),
      .carry_o (carry_w[k])
    );
  end

  // State register plus datapath and output registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      step_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      step_q  <= step_d;
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // Next state: accept a start (load wins) in IDLE, walk idx through the chain in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start_i && !load_i) begin
          state_d = RUN;
          idx_d   = IDX_W'(1);
        end
      end
      RUN: begin
        if (idx_q == IDX_W'(STAGES)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Datapath/output next values: load, stage writes, result commit and done pulse.
  always_comb begin
    count_d = count_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    step_d  = step_q;
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k] = stage_q[k];
    end
    case (state_q)
      IDLE: begin
        if (load_i) begin
          count_d = load_value_i;
          ovf_d   = 1'b0;
        end else if (start_i) begin
          step_d     = step_i;
          stage_d[0] = sum_w[0];
          ovf_d      = ovf_q | carry_w[0];
          ready_d    = 1'b0;
        end
      end
      RUN: begin
        if (idx_q == IDX_W'(STAGES)) begin
          count_d = stage_q[STAGES-1];
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          for (int k = 1; k < STAGES; k++) begin
            if (idx_q == IDX_W'(k)) begin
              stage_d[k] = sum_w[k];
              ovf_d      = ovf_q | carry_w[k];
            end
          end
        end
      end
      default: begin
        ready_d = 1'b1;
      end
    endcase
  end

  assign ready_o    = ready_q;
  assign count_o    = count_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign state_o    = state_q;

endmodule
